// File: rtl/accum_frame_ctrl.sv
// accum_frame_ctrl
//   Sequences a shared unsigned up-accumulator through fixed-length frames.
//   A start in IDLE latches the frame length and clears the accumulator.
//   Exactly that many samples are then summed over the din valid/ready
//   handshake. The sum is held on dout until the consumer accepts it.
//
// Optional build macro:
//   ACCUM_FRAME_CTRL_SATURATE_EN - when defined, a carry-out clamps acc to
//   all-ones. When undefined, acc wraps. overflow flags the carry in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   start/len  frame start request and length (len=0 -> 2^LENW samples)
//   clr        synchronous abort of the current frame
//   busy       controller is not idle
//   din_valid/din/din_ready    sample input handshake
//   dout_valid/dout/dout_ready result output handshake
//   overflow   frame sum exceeded 2^ACCW-1 (valid with dout_valid)
module accum_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int ACCW  = 8,
    parameter int LENW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LENW-1:0]  len,
    input  logic             clr,
    output logic             busy,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             dout_valid,
    output logic [ACCW-1:0]  dout,
    input  logic             dout_ready,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

    state_t          state, state_nxt;
    logic [ACCW-1:0] acc;
    logic [LENW-1:0] count;
    logic [LENW-1:0] len_q;
    logic            ovf;
    logic            beat;
    logic            last_beat;
    logic [ACCW:0]   sum;

    // One extra bit on the adder exposes the carry-out for overflow/saturation.
    assign sum       = {1'b0, acc} + {{(ACCW + 1 - WIDTH){1'b0}}, din};
    assign beat      = din_valid && din_ready;
    // Modulo-2^LENW compare: len_q=0 makes the final beat count = all-ones.
    assign last_beat = beat && (count == len_q - LENW'(1));

    assign busy       = (state != IDLE);
    assign din_ready  = (state == ACC);
    assign dout_valid = (state == DUMP);
    assign dout       = acc;
    assign overflow   = ovf;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = ACC;
            ACC: begin
                if (clr)            state_nxt = IDLE;
                else if (last_beat) state_nxt = DUMP;
            end
            DUMP: begin
                if (clr || dout_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                len_q <= len;
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (beat && !clr) begin
                // An abort drops the beat; acc is don't-care until the next start.
                count <= count + LENW'(1);
                ovf   <= ovf | sum[ACCW];
`ifdef ACCUM_FRAME_CTRL_SATURATE_EN
                // Once clamped, any further non-zero add carries again, so acc
                // stays pinned at all-ones for the rest of the frame.
                acc   <= sum[ACCW] ? {ACCW{1'b1}} : sum[ACCW-1:0];
`else
                acc   <= sum[ACCW-1:0];
`endif
            end
        end
    end

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// Self-checking bench for accum_frame_ctrl. Two instances share all inputs:
// one with ACCW=8 and one with ACCW=6 to exercise wrap/saturate. Each frame's
// expected result is computed from the plain integer sum of accepted samples.
module tb_accum_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       clr;
    logic       din_valid;
    logic [3:0] din;
    logic       dout_ready;

    logic       busy, din_ready, dout_valid, overflow;
    logic [7:0] dout;
    logic       busy6, din_ready6, dout_valid6, overflow6;
    logic [5:0] dout6;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] dv[$];

    always #5 clk = ~clk;

    accum_frame_ctrl #(.WIDTH(4), .ACCW(8), .LENW(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .clr(clr),
        .busy(busy), .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
        .overflow(overflow)
    );

    accum_frame_ctrl #(.WIDTH(4), .ACCW(6), .LENW(4)) u_dut6 (
        .clk(clk), .rst(rst), .start(start), .len(len), .clr(clr),
        .busy(busy6), .din_valid(din_valid), .din(din), .din_ready(din_ready6),
        .dout_valid(dout_valid6), .dout(dout6), .dout_ready(dout_ready),
        .overflow(overflow6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected frame result for an ACCW-bit accumulator given the true sum.
    function automatic int exp_res(input int total, input int w);
        int mx;
        mx = (1 << w) - 1;
`ifdef ACCUM_FRAME_CTRL_SATURATE_EN
        return (total > mx) ? mx : total;
`else
        return total & mx;
`endif
    endfunction

    task automatic chk_idle(input string tag, input bit after_rst);
        @(negedge clk);
        chk({tag, ".busy"},       32'(busy),        32'd0);
        chk({tag, ".din_ready"},  32'(din_ready),   32'd0);
        chk({tag, ".dout_valid"}, 32'(dout_valid),  32'd0);
        chk({tag, ".busy6"},      32'(busy6),       32'd0);
        chk({tag, ".dout_valid6"},32'(dout_valid6), 32'd0);
        if (after_rst) begin
            chk({tag, ".overflow"}, 32'(overflow), 32'd0);
            chk({tag, ".dout"},     32'(dout),     32'd0);
            chk({tag, ".dout6"},    32'(dout6),    32'd0);
        end
    endtask

    task automatic chk_dump(input string tag, input int total);
        chk({tag, ".dout_valid"}, 32'(dout_valid),  32'd1);
        chk({tag, ".din_ready"},  32'(din_ready),   32'd0);
        chk({tag, ".busy"},       32'(busy),        32'd1);
        chk({tag, ".dout"},       32'(dout),        32'(exp_res(total, 8)));
        chk({tag, ".ovf"},        32'(overflow),    32'(total > 255));
        chk({tag, ".dout_valid6"},32'(dout_valid6), 32'd1);
        chk({tag, ".dout6"},      32'(dout6),       32'(exp_res(total, 6)));
        chk({tag, ".ovf6"},       32'(overflow6),   32'(total > 63));
    endtask

    // One frame of n samples (1..16). abort_kind: 0 none, 1 clr, 2 rst.
    // abort_at < n aborts once that many beats are taken; abort_at >= n aborts in DUMP.
    // Sample values come from dv (front first) or are random when dv is empty.
    task automatic frame(input int n, input bit gaps, input int hold,
                         input int abort_kind, input int abort_at);
        int total = 0;
        int beats = 0;
        int cyc   = 0;
        start = 1'b1;
        len   = 4'(n);
        clr   = 1'($urandom_range(0, 1));   // start must win over clr in IDLE
        @(posedge clk); #1;
        start = 1'b0;
        clr   = 1'b0;
        while (beats < n && cyc < 200) begin
            if (abort_kind != 0 && beats == abort_at) begin
                din_valid = 1'b1;
                din       = 4'($urandom);
                if (abort_kind == 1) clr = 1'b1; else rst = 1'b0;
                @(posedge clk); #1;
                clr = 1'b0; rst = 1'b1; din_valid = 1'b0;
                chk_idle("abort_acc", abort_kind == 2);
                @(posedge clk); #1;
                return;
            end
            din_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            din       = (dv.size() > 0) ? dv[0] : 4'($urandom);
            @(negedge clk);
            chk("acc.busy",       32'(busy),       32'd1);
            chk("acc.din_ready",  32'(din_ready),  32'd1);
            chk("acc.dout_valid", 32'(dout_valid), 32'd0);
            @(posedge clk);
            if (din_valid) begin
                total += int'(din);
                beats++;
                if (dv.size() > 0) void'(dv.pop_front());
            end
            #1;
            cyc++;
        end
        din_valid = 1'b0;
        if (beats < n) begin
            chk("beat_timeout", 32'(beats), 32'(n));
            return;
        end
        for (int h = 0; h < hold; h++) begin
            dout_ready = 1'b0;
            start      = 1'($urandom_range(0, 1));
            len        = 4'($urandom);
            @(negedge clk);
            chk_dump("hold", total);
            @(posedge clk); #1;
        end
        if (abort_kind != 0) begin
            dout_ready = 1'($urandom_range(0, 1));   // abort wins over handshake
            if (abort_kind == 1) clr = 1'b1; else rst = 1'b0;
            @(posedge clk); #1;
            clr = 1'b0; rst = 1'b1; dout_ready = 1'b0; start = 1'b0;
            chk_idle("abort_dump", abort_kind == 2);
            @(posedge clk); #1;
            return;
        end
        dout_ready = 1'b1;
        start      = 1'($urandom_range(0, 1));       // ignored on handshake cycle
        @(negedge clk);
        chk_dump("hs", total);
        @(posedge clk); #1;
        dout_ready = 1'b0;
        start      = 1'b0;
        chk_idle("post_hs", 1'b0);
        @(posedge clk); #1;
        chk_idle("no_new_frame", 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; clr = 1'b0;
        din_valid = 1'b0; din = '0; dout_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_idle("reset", 1'b1);
        rst = 1'b1;
        // clr alone in IDLE does nothing
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk_idle("clr_idle", 1'b0);
        @(posedge clk); #1;

        dv = '{4'd5, 4'd7, 4'd9};          frame(3, 1'b0, 0, 0, 0);   // 21
        dv = '{};
        for (int i = 0; i < 16; i++) dv.push_back(4'd15);
        frame(16, 1'b1, 1, 0, 0);                                       // 240
        for (int i = 0; i < 5; i++) dv.push_back(4'd15);
        frame(5, 1'b0, 0, 0, 0);                                        // 75: 11/63 on ACCW=6
        dv = '{4'd3, 4'd4};                frame(2, 1'b0, 4, 0, 0);   // 7 held
        dv = '{};                          frame(4, 1'b0, 0, 1, 2);   // clr after 2 beats
        dv = '{4'd9};                      frame(1, 1'b0, 0, 0, 0);   // 9, no residue
        dv = '{};                          frame(6, 1'b1, 0, 1, 5);   // clr on final beat
        frame(4, 1'b0, 0, 2, 2);                                        // rst in ACC
        frame(3, 1'b0, 2, 2, 3);                                        // rst in DUMP
        dv = '{4'd1, 4'd2};                frame(2, 1'b0, 0, 0, 0);   // 3
        frame(3, 1'b0, 1, 1, 3);                                        // clr in DUMP
        for (int k = 0; k < 40; k++) begin
            int n, kind;
            dv.delete();
            n    = $urandom_range(1, 16);
            kind = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            frame(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), kind, $urandom_range(0, n));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/accum_frame_ctrl.md
Name: accum_frame_ctrl

Overview:
- Controller that sequences a shared unsigned up-accumulator through fixed-length frames.
- Per frame: takes a start command with a frame length, then accepts exactly that many input samples over a valid/ready handshake and accumulates them from zero.
- Presents the frame sum on a valid/ready output and holds it until accepted.
- Sits between a sample producer and a result consumer. Owns all clear/enable sequencing of the accumulator register.

Parameters:
- WIDTH, 4, input sample width (unsigned).
- ACCW, 8, accumulator and result width; must be >= WIDTH.
- LENW, 4, width of the frame-length field.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  frame start request; honoured only in IDLE.
- len  input  LENW  frame length, sampled with start; 0 means 2^LENW samples.
- clr  input  1  synchronous abort; drops the current frame.
- busy  output  1  high when not in IDLE.
- din_valid  input  1  sample valid.
- din  input  WIDTH  sample value.
- din_ready  output  1  controller accepts a sample this cycle.
- dout_valid  output  1  frame result valid.
- dout  output  ACCW  frame result (accumulator register).
- dout_ready  input  1  consumer accepts result.
- overflow  output  1  frame sum exceeded 2^ACCW-1; meaningful while dout_valid.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, acc=0, count=0, busy=0, din_ready=0, dout_valid=0, overflow=0. This overrides every other input. Reset mid-frame discards the frame silently.
- FSM states: IDLE, ACC, DUMP. busy = (state != IDLE).
- IDLE:
  - din_ready=0, dout_valid=0.
  - start=1: latch len, clear acc, count and overflow, go to ACC on the next cycle. One dead cycle from start to the first possible beat.
- ACC:
  - din_ready=1. din_ready is a function of state only, never of din_valid.
  - A beat occurs when din_valid && din_ready.
  - On a beat: acc <= acc + zero-extended din; count <= count+1; overflow |= carry-out of the ACCW-bit add.
  - Gaps (din_valid=0) stall without state change.
  - On the beat where count == latched_len-1 (modulo 2^LENW, so len=0 gives 2^LENW beats): go to DUMP.
- DUMP:
  - dout_valid=1 from the cycle after the final beat (1-cycle latency). dout and overflow held stable. din_ready=0.
  - dout_valid && dout_ready: go to IDLE next cycle. dout_valid drops.
- dout always equals the acc register. Only defined when dout_valid=1.
- start is ignored in ACC and DUMP, including the DUMP handshake cycle. There is no queuing.
- clr=1 in ACC or DUMP: go to IDLE next cycle. No result is presented; acc contents are don't-care until the next start. clr in IDLE has no effect.
- clr and start high together in IDLE: start wins.
- clr in the same cycle as a final beat or a DUMP handshake: clr wins. The beat or result is dropped.
- Width rule: all arithmetic is unsigned, ACCW bits. Without the optional feature the sum wraps modulo 2^ACCW.

Optional Feature:
- Macro: ACCUM_FRAME_CTRL_SATURATE_EN.
- Defined: when an add would carry out, acc <= 2^ACCW-1 and stays there for the rest of the frame. overflow=1 as before.
- Not defined: acc wraps modulo 2^ACCW; overflow=1 flags the wrap.
- Handshake, latency and FSM are identical in both builds.

Test Plan (WIDTH=4, ACCW=8, LENW=4 unless stated):
1. start, len=3; din 5,7,9 on three consecutive cycles with din_valid=1, dout_ready=1 -> dout_valid one cycle after the 3rd beat, dout=21, overflow=0, busy returns to 0 one cycle after the handshake.
2. len=0; 16 beats of din=15 with random din_valid gaps -> exactly 16 beats accepted, dout=240, overflow=0, din_ready=0 in DUMP.
3. Override ACCW=6; len=5, 5 beats of din=15 -> default build: dout=11, overflow=1; with ACCUM_FRAME_CTRL_SATURATE_EN: dout=63, overflow=1.
4. Frame of len=2 (din 3,4), dout_ready=0 for 4 cycles with start pulsed during DUMP -> dout_valid=1 and dout=7 stable throughout; on dout_ready=1, return to IDLE; no new frame started.
5. len=4; clr after 2 beats -> IDLE next cycle, dout_valid never asserts. Next start, len=1, din=9 -> dout=9, no residue from the aborted frame.
6. rst=0 during ACC and again during DUMP -> all outputs 0 after the edge. The following frame len=2 (din 1,2) gives dout=3.
